// File: rtl/control_sesion_cajero.sv
// control_sesion_cajero: cashier session controller.
// Detects the card, collects and verifies a BCD PIN with limited attempts,
// issues one deposit/withdrawal request to the transaction datapath, reports
// the result and ejects the card. All outputs are registered.
module control_sesion_cajero #(
    parameter int unsigned PIN_DIGITS     = 4,
    parameter int unsigned MAX_INTENTOS   = 3,
    parameter int unsigned TIMEOUT_CICLOS = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic [4*PIN_DIGITS-1:0] pin_correcto,
    input  logic [3:0]              digito,
    input  logic                    digito_stb,
    input  logic                    tipo_trans,
    input  logic [31:0]             monto,
    input  logic                    monto_stb,
    input  logic                    balance_stb,
    input  logic                    fondos_insuficientes,
    output logic                    trans_inicio,
    output logic                    trans_tipo,
    output logic [31:0]             trans_monto,
    output logic                    pin_incorrecto,
    output logic                    bloqueo,
    output logic                    operacion_ok,
    output logic                    error_fondos,
    output logic                    error_timeout,
    output logic                    expulsar_tarjeta,
    output logic [2:0]              estado
);

    localparam int unsigned PW = 4 * PIN_DIGITS;
    localparam int unsigned CW = $clog2(PIN_DIGITS + 1);
    localparam int unsigned IW = $clog2(MAX_INTENTOS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PIN          = 3'd1,
        VERIFICAR    = 3'd2,
        ESPERA_TRANS = 3'd3,
        EJECUTAR     = 3'd4,
        FIN          = 3'd5,
        BLOQUEO      = 3'd6
    } estado_t;

    estado_t        state_q, state_d;
    logic [PW-1:0]  pin_q, pin_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  int_q, int_d;
    logic [TW-1:0]  tout_q, tout_d;

    logic           ev_bad, ev_ok, ev_fondos, ev_tout, ev_monto, stb_ok;
    logic           tout_hit, counting;

    logic           trans_inicio_q, trans_inicio_d;
    logic           trans_tipo_q, trans_tipo_d;
    logic [31:0]    trans_monto_q, trans_monto_d;
    logic           pin_incorrecto_q, pin_incorrecto_d;
    logic           bloqueo_q, bloqueo_d;
    logic           operacion_ok_q, operacion_ok_d;
    logic           error_fondos_q, error_fondos_d;
    logic           error_timeout_q, error_timeout_d;
    logic           expulsar_q, expulsar_d;

    // State, session datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            pin_q            <= '0;
            cnt_q            <= '0;
            int_q            <= '0;
            tout_q           <= '0;
            trans_inicio_q   <= 1'b0;
            trans_tipo_q     <= 1'b0;
            trans_monto_q    <= '0;
            pin_incorrecto_q <= 1'b0;
            bloqueo_q        <= 1'b0;
            operacion_ok_q   <= 1'b0;
            error_fondos_q   <= 1'b0;
            error_timeout_q  <= 1'b0;
            expulsar_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            pin_q            <= pin_d;
            cnt_q            <= cnt_d;
            int_q            <= int_d;
            tout_q           <= tout_d;
            trans_inicio_q   <= trans_inicio_d;
            trans_tipo_q     <= trans_tipo_d;
            trans_monto_q    <= trans_monto_d;
            pin_incorrecto_q <= pin_incorrecto_d;
            bloqueo_q        <= bloqueo_d;
            operacion_ok_q   <= operacion_ok_d;
            error_fondos_q   <= error_fondos_d;
            error_timeout_q  <= error_timeout_d;
            expulsar_q       <= expulsar_d;
        end
    end

    // Next state, PIN capture, attempt and timeout counters
    always_comb begin
        state_d   = state_q;
        pin_d     = pin_q;
        cnt_d     = cnt_q;
        int_d     = int_q;
        ev_bad    = 1'b0;
        ev_ok     = 1'b0;
        ev_fondos = 1'b0;
        ev_tout   = 1'b0;
        ev_monto  = 1'b0;
        stb_ok    = 1'b0;
        tout_hit  = (tout_q == TW'(TIMEOUT_CICLOS - 1));
        counting  = (state_q == PIN) || (state_q == ESPERA_TRANS) || (state_q == EJECUTAR);

        case (state_q)
            IDLE: begin
                pin_d = '0;
                cnt_d = '0;
                int_d = '0;
                if (tarjeta_recibida) state_d = PIN;
            end
            PIN: begin
                if (!tarjeta_recibida) begin
                    state_d = IDLE;
                end else if (digito_stb && (digito <= 4'd9)) begin
                    stb_ok = 1'b1;
                    pin_d  = {pin_q[PW-5:0], digito};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(PIN_DIGITS - 1)) state_d = VERIFICAR;
                end else if (tout_hit) begin
                    ev_tout = 1'b1;
                    state_d = FIN;
                end
            end
            VERIFICAR: begin
                if (!tarjeta_recibida) begin
                    state_d = IDLE;
                end else if (pin_q == pin_correcto) begin
                    int_d   = '0;
                    state_d = ESPERA_TRANS;
                end else begin
                    ev_bad = 1'b1;
                    int_d  = int_q + 1'b1;
                    if (int_q == IW'(MAX_INTENTOS - 1)) begin
                        state_d = BLOQUEO;
                    end else begin
                        pin_d   = '0;
                        cnt_d   = '0;
                        state_d = PIN;
                    end
                end
            end
            ESPERA_TRANS: begin
                if (!tarjeta_recibida) begin
                    state_d = IDLE;
                end else if (monto_stb) begin
                    stb_ok   = 1'b1;
                    ev_monto = 1'b1;
                    state_d  = EJECUTAR;
                end else if (tout_hit) begin
                    ev_tout = 1'b1;
                    state_d = FIN;
                end
            end
            EJECUTAR: begin
                // Insufficient funds wins over a simultaneous balance_stb
                if (fondos_insuficientes) begin
                    ev_fondos = 1'b1;
                    state_d   = FIN;
                end else if (balance_stb) begin
                    ev_ok   = 1'b1;
                    state_d = FIN;
                end else if (tout_hit) begin
                    ev_tout = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            BLOQUEO: state_d = BLOQUEO;
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) || stb_ok || !counting) tout_d = '0;
        else                                             tout_d = tout_q + 1'b1;
    end

    // Output decode, registered one edge later so every pulse is glitch-free
    always_comb begin
        trans_inicio_d   = (state_d == EJECUTAR) && (state_q != EJECUTAR);
        trans_tipo_d     = ev_monto ? tipo_trans : trans_tipo_q;
        trans_monto_d    = ev_monto ? monto : trans_monto_q;
        pin_incorrecto_d = ev_bad;
        bloqueo_d        = (state_d == BLOQUEO);
        operacion_ok_d   = ev_ok;
        error_fondos_d   = ev_fondos;
        error_timeout_d  = ev_tout;
        expulsar_d       = (state_q == FIN);
    end

    assign trans_inicio     = trans_inicio_q;
    assign trans_tipo       = trans_tipo_q;
    assign trans_monto      = trans_monto_q;
    assign pin_incorrecto   = pin_incorrecto_q;
    assign bloqueo          = bloqueo_q;
    assign operacion_ok     = operacion_ok_q;
    assign error_fondos     = error_fondos_q;
    assign error_timeout    = error_timeout_q;
    assign expulsar_tarjeta = expulsar_q;
    assign estado           = state_q;

endmodule

// File: doc/control_sesion_cajero.md
# control_sesion_cajero

Session controller for the automatic-cashier transaction datapath. It detects card insertion, collects and verifies a BCD PIN with a bounded number of attempts, then issues exactly one deposit/withdrawal request per session to the transaction datapath. It collects the datapath's result, reports it, and ejects the card. It sits between the keypad/card front end and the transaction datapath, and is the only block that strobes that datapath.

## Interface

- PIN_DIGITS, 4, number of BCD digits in a PIN; pin_correcto width is 4*PIN_DIGITS
- MAX_INTENTOS, 3, wrong-PIN attempts allowed before blocking
- TIMEOUT_CICLOS, 1000, idle cycles tolerated in PIN, ESPERA_TRANS or EJECUTAR

Ports:

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- tarjeta_recibida  in  1  level, card present
- pin_correcto  in  4*PIN_DIGITS  stored PIN, most significant digit first
- digito  in  4  keypad digit (BCD)
- digito_stb  in  1  one-cycle strobe qualifying digito
- tipo_trans  in  1  0 = deposit, 1 = withdrawal
- monto  in  32  requested amount
- monto_stb  in  1  one-cycle strobe committing tipo_trans/monto
- balance_stb  in  1  datapath: transaction completed
- fondos_insuficientes  in  1  datapath: withdrawal rejected
- trans_inicio  out  1  one-cycle start strobe to datapath
- trans_tipo  out  1  registered tipo_trans
- trans_monto  out  32  registered monto
- pin_incorrecto  out  1  one-cycle pulse per wrong PIN
- bloqueo  out  1  level, card retained, session locked
- operacion_ok  out  1  one-cycle pulse, transaction succeeded
- error_fondos  out  1  one-cycle pulse, insufficient funds
- error_timeout  out  1  one-cycle pulse, session timed out
- expulsar_tarjeta  out  1  one-cycle pulse, eject card
- estado  out  3  current state encoding, for debug

## Operation

- States: IDLE, PIN, VERIFICAR, ESPERA_TRANS, EJECUTAR, FIN, BLOQUEO.
- IDLE: the digit register, digit count, attempt counter and timeout counter are cleared. tarjeta_recibida=1 moves the FSM to PIN.
- PIN:
  - digito_stb with digito ≤ 9 shifts the digit into the PIN register (left shift, new digit in the LSBs) and increments the count.
  - digito > 9 is ignored and not counted.
  - On the strobe that completes PIN_DIGITS digits, the FSM moves to VERIFICAR.
- VERIFICAR: one cycle; compares the captured register with pin_correcto.
  - Match: attempts cleared, go to ESPERA_TRANS.
  - Mismatch: pin_incorrecto pulses and attempts increment. If the count reaches MAX_INTENTOS, go to BLOQUEO; otherwise clear the digit register and count and return to PIN.
- ESPERA_TRANS: monto_stb latches trans_tipo/trans_monto and moves the FSM to EJECUTAR.
- EJECUTAR: trans_inicio is high exactly on the first cycle in this state. The FSM then waits for a datapath response:
  - balance_stb alone: operacion_ok pulses, go to FIN.
  - fondos_insuficientes, including when it coincides with balance_stb: error_fondos pulses, go to FIN.
- FIN: expulsar_tarjeta pulses for one cycle, then go to IDLE.
- BLOQUEO: bloqueo is held at 1. No other output pulses. Only reset exits this state.
- Card removal (tarjeta_recibida=0) in PIN, VERIFICAR or ESPERA_TRANS: go to IDLE next cycle with no pulses. Removal in EJECUTAR is ignored.
- Timeout counter:
  - Cleared on every state change and on every accepted digito_stb or monto_stb.
  - Counts in PIN, ESPERA_TRANS and EJECUTAR.
  - At TIMEOUT_CICLOS it forces FIN and pulses error_timeout.
- Strobes arriving in states other than those above are ignored.
- digito_stb in the VERIFICAR cycle is dropped.

## Timing

- Reset: state IDLE, and every output is 0 (including trans_monto, trans_tipo, bloqueo and estado).
- All outputs are registered; pulses last exactly one cycle.
- The last digit strobe at edge N puts the FSM in VERIFICAR after N. The verdict (pin_incorrecto, or entry to ESPERA_TRANS) follows at N+1.
- monto_stb at edge N produces trans_inicio=1 during the cycle after N. trans_monto and trans_tipo are stable from that cycle until the next monto_stb.
- A datapath response at edge M produces operacion_ok or error_fondos after M, and expulsar_tarjeta one cycle later.
- Reset asserted mid-session takes priority over every input and returns the block to IDLE on the next edge.

## Test plan

- Correct PIN: pin_correcto=16'h1234, digits 1,2,3,4, deposit monto=500, balance_stb → trans_inicio once with trans_monto=500, trans_tipo=0; then operacion_ok, then expulsar_tarjeta; back to IDLE.
- Wrong PIN three times (e.g. 9,9,9,9) → three pin_incorrecto pulses, then bloqueo=1 held; a later correct PIN and monto_stb produce no trans_inicio; reset clears bloqueo.
- Two wrong PINs then the correct PIN → two pin_incorrecto pulses, then normal withdrawal; fondos_insuficientes=1 → error_fondos, expulsar_tarjeta, no operacion_ok.
- balance_stb and fondos_insuficientes high in the same cycle → error_fondos only.
- Digit 4'hA inside a PIN sequence → ignored, PIN still accepted after 4 valid digits; card removed in ESPERA_TRANS → IDLE, no expulsar_tarjeta.
- No input for TIMEOUT_CICLOS in PIN → error_timeout then expulsar_tarjeta; reset in EJECUTAR → IDLE, all outputs 0 next cycle.
